// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive framer and the TX core:
//   - cfg word bit positions (stop select, parity enable/even, data length)
//   - data-length base (data bits = DATA_LEN_BASE + data_len)
//   - framer state encoding
//   - receive FIFO entry layout and a 2-of-3 majority helper
// -----------------------------------------------------------------------------
package uart_pkg;

   // cfg word layout
   localparam int CFG_STOP_SEL = 4;   // 1 = two stop bits
   localparam int CFG_PAR_EN   = 3;   // 1 = parity bit present
   localparam int CFG_PAR_EVEN = 2;   // 1 = even parity, 0 = odd
   localparam int CFG_LEN_HI   = 1;   // data_len field msb
   localparam int CFG_LEN_LO   = 0;   // data_len field lsb

   // Number of data bits is DATA_LEN_BASE + data_len (5..8)
   localparam int DATA_LEN_BASE = 5;

   // Framer state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   // Receive FIFO entry: data plus per-frame error flags
   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } rx_entry_t;

   localparam int RX_ENTRY_W = $bits(rx_entry_t);

   // 2-of-3 majority vote used for bit-centre sampling
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// -----------------------------------------------------------------------------
// uart_rx_framer_if
// Receive-side consumer handshake of the UART framer.
//   rx_data  : FIFO head data, LSB = first received bit
//   rx_perr  : FIFO head parity-error flag
//   rx_ferr  : FIFO head framing-error flag
//   rx_valid : FIFO not empty
//   rx_ready : consumer pop request (effective only while rx_valid=1)
// master = framer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_framer_if;

   logic [7:0] rx_data;
   logic       rx_perr;
   logic       rx_ferr;
   logic       rx_valid;
   logic       rx_ready;

   modport master (
      output rx_data,
      output rx_perr,
      output rx_ferr,
      output rx_valid,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_perr,
      input  rx_ferr,
      input  rx_valid,
      output rx_ready
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Small synchronous FIFO holding completed receive frames.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and data; ignored when full unless a pop
//              happens in the same cycle
//   pop      : read request; ignored when empty
//   dout     : head entry (0 while empty), valid the cycle after the push edge
//   full, empty, count : occupancy status (count 0..DEPTH)
// DEPTH must be a power of two (2..16) so pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [4:0]       count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [4:0]       count_reg;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_reg == 5'(DEPTH));
   assign empty = (count_reg == 5'd0);
   assign count = count_reg;

   // A pop frees the head slot this cycle, so a push on a full FIFO
   // is still accepted when paired with a pop.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Storage needs no reset: the head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= din;
      end
   end

   assign dout = empty ? '0 : mem_reg[rd_ptr_reg];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 5'd1;
            2'b01:   count_reg <= count_reg - 5'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_framer.sv
// -----------------------------------------------------------------------------
// uart_rx_framer
// UART receive framer with 16x oversampling and a receive FIFO.
//   clk, rst   : system clock, asynchronous active-high reset
//   clk16      : one-clk-wide 16x-baud tick enable
//   rx_sn      : serial line (idle high, asynchronous to clk)
//   cfg        : [4] two stop bits, [3] parity enable, [2] even parity,
//                [1:0] data_len (5+data_len data bits); latched per frame
//   rx         : consumer handshake (data, perr, ferr, valid, ready)
//   rx_overrun : sticky, a completed frame was dropped on a full FIFO
//   ovr_clr    : clears rx_overrun (a same-cycle overrun wins)
//   rx_busy    : framer not idle
//   fifo_count : FIFO occupancy 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module uart_rx_framer
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4   // power of two, 2..16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clk16,
   input  logic                     rx_sn,
   input  logic [4:0]               cfg,
   uart_rx_framer_if.master         rx,
   output logic                     rx_overrun,
   input  logic                     ovr_clr,
   output logic                     rx_busy,
   output logic [4:0]               fifo_count
);

   logic       sync1_reg;
   logic       rxs_reg;
   logic [2:0] state_reg;
   logic [3:0] tcnt_reg;
   logic [2:0] bcnt_reg;
   logic       stop2_reg;
   logic       s7_reg;
   logic       s8_reg;
   logic [7:0] data_reg;
   logic       perr_reg;
   logic       ferr_reg;
   logic [4:0] cfg_frame_reg;
   logic       ovr_reg;

   logic       maj;
   logic       decide;
   logic [2:0] last_idx;
   logic       frame_done;
   logic       pop_eff;
   logic       drop;
   logic       fifo_full;
   logic       fifo_empty;
   rx_entry_t  push_entry;
   rx_entry_t  head_entry;

   // Third sample is the live synchronised value at tcnt 9
   assign maj      = maj3(s7_reg, s8_reg, rxs_reg);
   assign decide   = clk16 & (tcnt_reg == 4'd9);
   assign last_idx = 3'(DATA_LEN_BASE - 1) + {1'b0, cfg_frame_reg[CFG_LEN_HI:CFG_LEN_LO]};

   // Completion at the decision point of the final stop bit
   assign frame_done = decide & (state_reg == ST_STOP) &
                       (~cfg_frame_reg[CFG_STOP_SEL] | stop2_reg);

   // The current stop bit's verdict is folded in directly since ferr_reg
   // only updates on this same edge.
   always_comb begin
      push_entry      = '0;
      push_entry.data = data_reg;
      push_entry.perr = perr_reg;
      push_entry.ferr = ferr_reg | ~maj;
   end

   assign pop_eff = rx.rx_ready & ~fifo_empty;
   assign drop    = frame_done & fifo_full & ~pop_eff;

   uart_rx_fifo #(
      .WIDTH (RX_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (frame_done),
      .din   (push_entry),
      .pop   (rx.rx_ready),
      .dout  (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign rx.rx_data  = head_entry.data;
   assign rx.rx_perr  = head_entry.perr;
   assign rx.rx_ferr  = head_entry.ferr;
   assign rx.rx_valid = ~fifo_empty;
   assign rx_busy     = (state_reg != ST_IDLE);
   assign rx_overrun  = ovr_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovr_reg <= 1'b0;
      end else if (drop) begin
         ovr_reg <= 1'b1;
      end else if (ovr_clr) begin
         ovr_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg     <= 1'b1;
         rxs_reg       <= 1'b1;
         state_reg     <= ST_IDLE;
         tcnt_reg      <= 4'd0;
         bcnt_reg      <= 3'd0;
         stop2_reg     <= 1'b0;
         s7_reg        <= 1'b1;
         s8_reg        <= 1'b1;
         data_reg      <= 8'd0;
         perr_reg      <= 1'b0;
         ferr_reg      <= 1'b0;
         cfg_frame_reg <= 5'd0;
      end else begin
         sync1_reg <= rx_sn;
         rxs_reg   <= sync1_reg;

         if (state_reg == ST_IDLE) begin
            // Start detection is a plain level check, so it also fires on
            // the cycle right after a frame completes.
            if (!rxs_reg) begin
               state_reg     <= ST_START;
               tcnt_reg      <= 4'd0;
               bcnt_reg      <= 3'd0;
               stop2_reg     <= 1'b0;
               data_reg      <= 8'd0;
               perr_reg      <= 1'b0;
               ferr_reg      <= 1'b0;
               cfg_frame_reg <= cfg;
            end
         end else if (clk16) begin
            // tcnt runs freely; states change at tcnt 9 and the next bit's
            // samples land after the 15->0 wrap.
            tcnt_reg <= tcnt_reg + 4'd1;
            if (tcnt_reg == 4'd7) begin
               s7_reg <= rxs_reg;
            end
            if (tcnt_reg == 4'd8) begin
               s8_reg <= rxs_reg;
            end
            if (decide) begin
               case (state_reg)
                  ST_START: begin
                     state_reg <= maj ? ST_IDLE : ST_DATA;
                  end
                  ST_DATA: begin
                     data_reg[bcnt_reg] <= maj;
                     if (bcnt_reg == last_idx) begin
                        state_reg <= cfg_frame_reg[CFG_PAR_EN] ? ST_PARITY : ST_STOP;
                     end else begin
                        bcnt_reg <= bcnt_reg + 3'd1;
                     end
                  end
                  ST_PARITY: begin
                     // Even: total XOR must be 0; odd: must be 1
                     perr_reg  <= (^data_reg) ^ maj ^ ~cfg_frame_reg[CFG_PAR_EVEN];
                     state_reg <= ST_STOP;
                  end
                  ST_STOP: begin
                     ferr_reg <= ferr_reg | ~maj;
                     if (frame_done) begin
                        state_reg <= ST_IDLE;
                     end else begin
                        stop2_reg <= 1'b1;
                     end
                  end
                  default: begin
                     state_reg <= ST_IDLE;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_framer
// Directed stimulus for uart_rx_framer: clean 8N1 frame, parity error,
// framing error on the second stop bit, start-bit glitch, FIFO overrun and
// reset in the middle of a frame. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_uart_rx_framer;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       clk16   = 1'b0;
   logic       rx_sn   = 1'b1;
   logic [4:0] cfg     = 5'd0;
   logic       ovr_clr = 1'b0;
   logic       rx_overrun;
   logic       rx_busy;
   logic [4:0] fifo_count;

   int total = 0;
   int bad   = 0;

   uart_rx_framer_if rx_if ();

   uart_rx_framer #(
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clk16      (clk16),
      .rx_sn      (rx_sn),
      .cfg        (cfg),
      .rx         (rx_if),
      .rx_overrun (rx_overrun),
      .ovr_clr    (ovr_clr),
      .rx_busy    (rx_busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   // One tick every 4 clocks, changed on the falling edge
   initial begin
      forever begin
         repeat (3) @(negedge clk);
         clk16 = 1'b1;
         @(negedge clk);
         clk16 = 1'b0;
      end
   end

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (!clk16) @(posedge clk);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      rx_sn = b;
      wait_ticks(16);
   endtask

   task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                             input logic par_bit, input logic two_stop, input logic stop2_val);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) begin
         send_bit(data[i]);
      end
      if (par_en) begin
         send_bit(par_bit);
      end
      send_bit(1'b1);
      if (two_stop) begin
         send_bit(stop2_val);
      end
      @(negedge clk);
      rx_sn = 1'b1;
      wait_ticks(24);
      @(negedge clk);
      $display("frame sent: data=%02h bits=%0d cfg=%05b count=%0d", data, nbits, cfg, fifo_count);
   endtask

   task automatic pop_one();
      @(negedge clk);
      rx_if.rx_ready = 1'b1;
      @(negedge clk);
      rx_if.rx_ready = 1'b0;
   endtask

   initial begin
      rx_if.rx_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(rx_if.rx_valid), 32'd0);
      check("rst_data", 32'(rx_if.rx_data), 32'd0);
      check("rst_perr", 32'(rx_if.rx_perr), 32'd0);
      check("rst_ferr", 32'(rx_if.rx_ferr), 32'd0);
      check("rst_ovr", 32'(rx_overrun), 32'd0);
      check("rst_busy", 32'(rx_busy), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // 8N1, 0xA5
      cfg = 5'b00011;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      check("a5_valid", 32'(rx_if.rx_valid), 32'd1);
      check("a5_data", 32'(rx_if.rx_data), 32'hA5);
      check("a5_perr", 32'(rx_if.rx_perr), 32'd0);
      check("a5_ferr", 32'(rx_if.rx_ferr), 32'd0);
      check("a5_count", 32'(fifo_count), 32'd1);
      pop_one();
      check("a5_pop_count", 32'(fifo_count), 32'd0);
      check("a5_pop_valid", 32'(rx_if.rx_valid), 32'd0);

      // 8E1, 0x3C with wrong parity bit 1
      cfg = 5'b01111;
      send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0, 1'b1);
      check("3c_data", 32'(rx_if.rx_data), 32'h3C);
      check("3c_perr", 32'(rx_if.rx_perr), 32'd1);
      check("3c_ferr", 32'(rx_if.rx_ferr), 32'd0);
      pop_one();

      // 5N2, 0x15 with second stop bit 0
      cfg = 5'b10000;
      send_frame(8'h15, 5, 1'b0, 1'b0, 1'b1, 1'b0);
      check("15_data", 32'(rx_if.rx_data), 32'h15);
      check("15_ferr", 32'(rx_if.rx_ferr), 32'd1);
      check("15_perr", 32'(rx_if.rx_perr), 32'd0);
      check("15_count", 32'(fifo_count), 32'd1);
      pop_one();

      // 4-tick glitch low on idle line
      cfg = 5'b00011;
      @(negedge clk);
      rx_sn = 1'b0;
      wait_ticks(4);
      @(negedge clk);
      check("glitch_busy_hi", 32'(rx_busy), 32'd1);
      rx_sn = 1'b1;
      wait_ticks(20);
      @(negedge clk);
      $display("glitch sent: busy=%0d count=%0d", rx_busy, fifo_count);
      check("glitch_busy_lo", 32'(rx_busy), 32'd0);
      check("glitch_count", 32'(fifo_count), 32'd0);

      // Overrun: five frames into a 4-deep FIFO
      for (int v = 1; v <= 5; v++) begin
         send_frame(8'(v), 8, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      check("ovr_count", 32'(fifo_count), 32'd4);
      check("ovr_flag", 32'(rx_overrun), 32'd1);
      for (int v = 1; v <= 4; v++) begin
         check($sformatf("ovr_pop%0d", v), 32'(rx_if.rx_data), 32'(v));
         pop_one();
      end
      check("ovr_empty", 32'(fifo_count), 32'd0);
      check("ovr_sticky", 32'(rx_overrun), 32'd1);
      @(negedge clk);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      check("ovr_clr", 32'(rx_overrun), 32'd0);

      // Reset during the data bits of 0x55
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      @(negedge clk);
      check("mid_busy", 32'(rx_busy), 32'd1);
      rst   = 1'b1;
      rx_sn = 1'b1;
      repeat (4) @(negedge clk);
      check("mid_rst_busy", 32'(rx_busy), 32'd0);
      rst = 1'b0;
      wait_ticks(20);
      @(negedge clk);
      $display("reset mid-frame: busy=%0d count=%0d", rx_busy, fifo_count);
      check("post_rst_count", 32'(fifo_count), 32'd0);
      send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      check("81_count", 32'(fifo_count), 32'd1);
      check("81_data", 32'(rx_if.rx_data), 32'h81);
      pop_one();
      check("81_pop_valid", 32'(rx_if.rx_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
